div_sched: RTL and testbench

Round-robin scheduler that shares one 32-bit sequential `divider` instance between `NREQ` requesters. It owns the divider's `start`/`A`/`B` inputs and holds `start` high for the whole operation, because dropping `start` clears the divider. It captures `D`/`R` when `ok` returns and hands each result back with the requester's ID. Divide-by-zero requests are resolved locally without launching the divider. Sits between client logic and the divider in the arithmetic subsystem.

---
 rtl/div_sched.sv | 133 +++++++++++++
 tb/tb_div_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// Round-robin front end sharing one 32-bit sequential divider between NREQ clients.
// Holds div_start for the whole operation; divide-by-zero is answered without the divider.
//   state   | meaning
//   IDLE    | arbitrating, req_ready may be non-zero
//   WAIT_LO | div_start high, waiting for the divider to drop ok
//   WAIT_HI | divider running, waiting for ok to return
//   RESP    | one-entry response buffer full, waiting for resp_ready
module div_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MAX_CYC = 48
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_q,
  output logic [31:0]          resp_r,
  output logic                 resp_err,
  output logic                 div_start,
  output logic [31:0]          div_a,
  output logic [31:0]          div_b,
  input  logic [31:0]          div_d,
  input  logic [31:0]          div_r,
  input  logic                 div_ok,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI, RESP} state_t;

  localparam logic [6:0] WD_LIM = 7'(MAX_CYC);

  state_t         state;
  logic [IDW-1:0] last;
  logic [6:0]     wd_cnt;
  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;

  // search starts just after the last winner so a held request yields to others
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (int'(last) + k) % NREQ;
      if (!grant_any && req_valid[c]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(c);
      end
    end
    if (state != IDLE) grant_any = 1'b0;
    req_ready = '0;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign sel_a = req_a[32*int'(grant_idx) +: 32];
  assign sel_b = req_b[32*int'(grant_idx) +: 32];
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last       <= IDW'(NREQ-1);
      wd_cnt     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_q     <= '0;
      resp_r     <= '0;
      resp_err   <= 1'b0;
      div_start  <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            resp_id <= grant_idx;
            last    <= grant_idx;
            if (sel_b == 32'd0) begin
              resp_q     <= '1;
              resp_r     <= sel_a;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              div_a     <= sel_a;
              div_b     <= sel_b;
              div_start <= 1'b1;
              wd_cnt    <= '0;
              state     <= WAIT_LO;
            end
          end
        end
        WAIT_LO, WAIT_HI: begin
          wd_cnt <= wd_cnt + 7'd1;
          // watchdog wins over a coincident ok so a stuck divider cannot look healthy
          if (wd_cnt == WD_LIM) begin
            div_start  <= 1'b0;
            resp_q     <= '0;
            resp_r     <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (state == WAIT_LO) begin
            if (!div_ok) state <= WAIT_HI;
          end else if (div_ok) begin
            resp_q     <= div_d;
            resp_r     <= div_r;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            div_start  <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched with a behavioural 32-cycle divider model.
module tb_div_sched;
  localparam int NREQ = 4, IDW = 2, MAX_CYC = 48;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [32*NREQ-1:0] req_a = '0;
  logic [32*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [IDW-1:0]    resp_id;
  logic [31:0]       resp_q, resp_r;
  logic              resp_err;
  logic              div_start;
  logic [31:0]       div_a, div_b, div_d, div_r;
  logic              div_ok;
  logic              busy;
  logic              stub = 1'b0;

  always #5 clk = ~clk;

  div_sched #(.NREQ(NREQ), .IDW(IDW), .MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_q(resp_q), .resp_r(resp_r), .resp_err(resp_err),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_d(div_d),
    .div_r(div_r), .div_ok(div_ok), .busy(busy));

  // divider model: load on first start edge, ok low 32 cycles, restart if start held
  logic        m_ok = 1'b0, m_loaded = 1'b0;
  logic [5:0]  m_cnt = '0;
  logic [31:0] m_a = '0, m_b = '0, m_d = '0, m_r = '0;
  always @(posedge clk) begin
    if (!div_start) begin
      m_loaded <= 1'b0; m_cnt <= '0; m_ok <= 1'b0;
    end else if (!m_loaded || (m_cnt == 0 && m_ok)) begin
      m_loaded <= 1'b1; m_a <= div_a; m_b <= div_b; m_cnt <= 6'd32; m_ok <= 1'b0;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 6'd1;
    end else if (m_cnt == 1) begin
      m_cnt <= '0; m_ok <= 1'b1;
      m_d <= (m_b == 0) ? '1 : m_a / m_b;
      m_r <= (m_b == 0) ? m_a : m_a % m_b;
    end
  end
  assign div_ok = stub ? 1'b1 : m_ok;
  assign div_d  = m_d;
  assign div_r  = m_r;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    q;
    logic [31:0]    r;
    logic           err;
    int             lat;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0, fails = 0;
  int cyc = 0, grant_cyc = 0, grant_cnt = 0, rise_cyc = 0, accept_cyc = 0, resp_cnt = 0;
  logic prev_v = 1'b0;
  logic start_seen = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] q, input logic [31:0] r,
                          input logic err, input int lat);
    exp_t e;
    e.id = IDW'(id); e.q = q; e.r = r; e.err = err; e.lat = lat;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (div_start) start_seen = 1'b1;
    if (!reset) begin
      prev_v = 1'b0;
    end else begin
      if (|(req_valid & req_ready)) begin
        grant_cyc = cyc;
        grant_cnt++;
      end
      if (resp_valid && !prev_v) rise_cyc = cyc;
      if (resp_valid && resp_ready) begin
        accept_cyc = cyc;
        resp_cnt++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: got id %0d q %0h, expected no response", resp_id, resp_q);
        end else begin
          e = exp_q.pop_front();
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_q", 64'(resp_q), 64'(e.q));
          chk("resp_r", 64'(resp_r), 64'(e.r));
          chk("resp_err", 64'(resp_err), 64'(e.err));
          chk("latency", 64'(rise_cyc - grant_cyc), 64'(e.lat));
        end
      end
      prev_v = resp_valid;
    end
  end

  task automatic wait_grant(input int g0);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (grant_cnt != g0) break;
    end
    #1;
    chk("grant_seen", 64'(grant_cnt != g0), 64'd1);
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b);
    int g0;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_valid[id] = 1'b1;
    g0 = grant_cnt;
    wait_grant(g0);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (resp_cnt >= n) break;
    end
    #1;
    chk("resp_seen", 64'(resp_cnt >= n), 64'd1);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ctrl"}, 64'({req_ready, resp_valid, resp_id, resp_err, div_start, busy}), 64'd0);
    chk({nm, "_qr"}, {resp_q, resp_r}, 64'd0);
    chk({nm, "_ab"}, {div_a, div_b}, 64'd0);
  endtask

  initial begin
    int g0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(posedge clk); #1 reset = 1'b1;

    // single divide
    push_exp(0, 32'd14, 32'd2, 1'b0, 35);
    issue(0, 32'd100, 32'd7);
    wait_resp(1);

    // divide by zero, divider never started
    start_seen = 1'b0;
    push_exp(2, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
    issue(2, 32'h1234, 32'd0);
    wait_resp(2);
    chk("zero_no_start", 64'(start_seen), 64'd0);

    // backpressure with another request waiting
    resp_ready = 1'b0;
    push_exp(1, 32'd8, 32'd2, 1'b0, 35);
    push_exp(3, 32'd2, 32'd1, 1'b0, 35);
    issue(1, 32'd50, 32'd6);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (resp_valid) break;
    end
    #1;
    req_a[96 +: 32] = 32'd9;
    req_b[96 +: 32] = 32'd4;
    req_valid[3] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_ctrl", 64'({resp_valid, resp_err, resp_id, req_ready}), 64'({1'b1, 1'b0, 2'd1, 4'b0000}));
      chk("bp_qr", {resp_q, resp_r}, {32'd8, 32'd2});
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    g0 = grant_cnt;
    wait_grant(g0);
    req_valid[3] = 1'b0;
    chk("bp_regrant_gap", 64'(grant_cyc - accept_cyc), 64'd1);
    wait_resp(4);

    // round robin with all requesters held
    req_a = {32'd12345, 32'd1000, 32'hFFFF_FFFF, 32'd100};
    req_b = {32'd100, 32'd10, 32'h10, 32'd7};
    push_exp(0, 32'd14, 32'd2, 1'b0, 35);
    push_exp(1, 32'h0FFF_FFFF, 32'hF, 1'b0, 35);
    push_exp(2, 32'd100, 32'd0, 1'b0, 35);
    push_exp(3, 32'd123, 32'd45, 1'b0, 35);
    push_exp(0, 32'd14, 32'd2, 1'b0, 35);
    g0 = grant_cnt;
    req_valid = 4'hF;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (grant_cnt >= g0 + 5) break;
    end
    #1 req_valid = '0;
    chk("rr_grants", 64'(grant_cnt - g0), 64'd5);
    wait_resp(9);

    // watchdog against a divider stuck with ok high
    stub = 1'b1;
    push_exp(3, 32'd0, 32'd0, 1'b1, MAX_CYC + 2);
    issue(3, 32'd5, 32'd3);
    wait_resp(10);
    stub = 1'b0;

    // reset in the middle of an operation
    issue(1, 32'd77, 32'd5);
    repeat (19) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_zero("midreset");
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b1;
    req_a[0 +: 32]  = 32'd60;  req_b[0 +: 32]  = 32'd3;
    req_a[32 +: 32] = 32'd77;  req_b[32 +: 32] = 32'd5;
    push_exp(0, 32'd20, 32'd0, 1'b0, 35);
    push_exp(1, 32'd15, 32'd2, 1'b0, 35);
    g0 = grant_cnt;
    req_valid = 4'b0011;
    wait_grant(g0);
    req_valid[0] = 1'b0;
    wait_grant(g0 + 1);
    req_valid[1] = 1'b0;
    wait_resp(12);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
